// File: rtl/tone_gen.sv
// Buzzer tone generator: plays 4-bit note codes as a square wave and only switches note on
// half-period boundaries. Define TONE_GEN_HIGH_OCTAVE_EN to play codes 9-15 one octave up.
module tone_gen #(
    parameter int unsigned CLK_HZ = 4000000,
    parameter int unsigned CNT_W  = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] mode,
    output logic       buzz,
    output logic       tone_on,
    output logic       note_start,
    output logic [3:0] active_mode
);

    localparam logic [3:0] RestCode = 4'd8;

    // Half-period counts; note frequencies are in centi-Hz.
    localparam int unsigned Half0 = (CLK_HZ * 50) / 26163;
    localparam int unsigned Half1 = (CLK_HZ * 50) / 29366;
    localparam int unsigned Half2 = (CLK_HZ * 50) / 32963;
    localparam int unsigned Half3 = (CLK_HZ * 50) / 34923;
    localparam int unsigned Half4 = (CLK_HZ * 50) / 39200;
    localparam int unsigned Half5 = (CLK_HZ * 50) / 44000;
    localparam int unsigned Half6 = (CLK_HZ * 50) / 49388;
    localparam int unsigned Half7 = (CLK_HZ * 50) / 52325;

    typedef enum logic [0:0] {StRest, StTone} state_e;

    state_e           state_q;
    logic [3:0]       mode_q;
    logic [3:0]       active_mode_q;
    logic [CNT_W-1:0] cnt_q;
    logic             buzz_q;
    logic             tone_on_q;
    logic             note_start_q;

    int unsigned      half_full;
    logic [CNT_W-1:0] half_m1;
    logic             mode_tone;
    logic             at_boundary;
    logic             do_switch;

    function automatic logic is_tone(input logic [3:0] code);
`ifdef TONE_GEN_HIGH_OCTAVE_EN
        return code != RestCode;
`else
        return !code[3];
`endif
    endfunction

    always_comb begin
        half_full = Half0;
        unique case (active_mode_q[2:0])
            3'd0: half_full = Half0;
            3'd1: half_full = Half1;
            3'd2: half_full = Half2;
            3'd3: half_full = Half3;
            3'd4: half_full = Half4;
            3'd5: half_full = Half5;
            3'd6: half_full = Half6;
            3'd7: half_full = Half7;
            default: half_full = Half0;
        endcase
        // Upper codes are an octave up; in the default build they are rests and never count.
        if (active_mode_q[3]) begin
            half_full = half_full >> 1;
        end
        half_m1 = CNT_W'(half_full - 1);
    end

    assign mode_tone   = is_tone(mode_q);
    assign at_boundary = (state_q == StRest) || (cnt_q == half_m1);
    assign do_switch   = (mode_q != active_mode_q) && at_boundary;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StRest;
            mode_q        <= RestCode;
            active_mode_q <= RestCode;
            cnt_q         <= '0;
            buzz_q        <= 1'b0;
            tone_on_q     <= 1'b0;
            note_start_q  <= 1'b0;
        end else begin
            mode_q       <= mode;
            note_start_q <= 1'b0;
            if (do_switch) begin
                active_mode_q <= mode_q;
                tone_on_q     <= mode_tone;
                note_start_q  <= mode_tone;
                state_q       <= mode_tone ? StTone : StRest;
                cnt_q         <= '0;
                buzz_q        <= 1'b0;
            end else if (state_q == StTone) begin
                if (cnt_q == half_m1) begin
                    cnt_q  <= '0;
                    buzz_q <= ~buzz_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q  <= '0;
                buzz_q <= 1'b0;
            end
        end
    end

    assign buzz        = buzz_q;
    assign tone_on     = tone_on_q;
    assign note_start  = note_start_q;
    assign active_mode = active_mode_q;

endmodule
